instruction_fetch: RTL and testbench

//  Fetch stage directly upstream of OpcodeDecoder: owns the program counter and issues
//  one-outstanding-request reads to instruction memory. Presents each 32-bit word with its

---
 rtl/instruction_fetch.sv | 104 ++++++++++
 tb/tb_instruction_fetch.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner issuing single-outstanding instruction reads, with redirect and stale-fetch drain
module instruction_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Enable,
    output logic                  MemRead,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    input  logic                  MemReady,
    input  logic [31:0]           MemData,
    input  logic                  Redirect,
    input  logic [ADDR_WIDTH-1:0] RedirectPc,
    output logic                  InstrValid,
    input  logic                  InstrReady,
    output logic [31:0]           Instr,
    output logic [ADDR_WIDTH-1:0] InstrPc,
    output logic [ADDR_WIDTH-1:0] Pc
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc_next, addr_next, ipc_next, redirect_pc;
    logic [31:0]           instr_next;
    logic                  read_next, valid_next, redirect_low_unused;

    assign redirect_pc         = {RedirectPc[ADDR_WIDTH-1:2], 2'b00};
    assign redirect_low_unused = ^RedirectPc[1:0];

    // State register; every output is registered from its next value
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            Pc         <= RESET_PC;
            MemRead    <= 1'b0;
            MemAddr    <= '0;
            InstrValid <= 1'b0;
            Instr      <= '0;
            InstrPc    <= '0;
        end else begin
            state      <= state_next;
            Pc         <= pc_next;
            MemRead    <= read_next;
            MemAddr    <= addr_next;
            InstrValid <= valid_next;
            Instr      <= instr_next;
            InstrPc    <= ipc_next;
        end
    end

    // Next state and next outputs; a redirect always retargets the PC, the
    // outstanding request address never changes until memory answers
    always_comb begin
        state_next = state;
        pc_next    = Redirect ? redirect_pc : Pc;
        read_next  = MemRead;
        addr_next  = MemAddr;
        valid_next = InstrValid;
        instr_next = Instr;
        ipc_next   = InstrPc;
        case (state)
            IDLE: begin
                if (!Redirect && Enable) begin
                    state_next = FETCH;
                    read_next  = 1'b1;
                    addr_next  = Pc;
                end
            end
            FETCH: begin
                if (MemReady && Redirect) begin
                    state_next = Enable ? FETCH : IDLE;
                    read_next  = Enable;
                    addr_next  = Enable ? redirect_pc : MemAddr;
                end else if (MemReady) begin
                    state_next = HOLD;
                    instr_next = MemData;
                    ipc_next   = MemAddr;
                    valid_next = 1'b1;
                    pc_next    = Pc + ADDR_WIDTH'(4);
                    read_next  = 1'b0;
                end else if (Redirect) begin
                    state_next = DRAIN;
                end
            end
            HOLD: begin
                if (Redirect || InstrReady) begin
                    valid_next = 1'b0;
                    state_next = Enable ? FETCH : IDLE;
                    read_next  = Enable;
                    addr_next  = Enable ? pc_next : MemAddr;
                end
            end
            DRAIN: begin
                if (MemReady) begin
                    state_next = Enable ? FETCH : IDLE;
                    read_next  = Enable;
                    addr_next  = Enable ? pc_next : MemAddr;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed bench with a delivered-stream model and per-cycle protocol checks
module tb_instruction_fetch;
    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        Reset, Enable, MemRead, MemReady, Redirect, InstrValid, InstrReady, force_ready;
    logic [31:0] MemAddr, MemData, RedirectPc, Instr, InstrPc, Pc;
    logic        r1, v1;
    logic [31:0] a1, i1, ip1, pc1;
    int          mem_wait = 0, wcnt = 0, checks = 0, errors = 0, hs_count = 0, hs_mark;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == 32'h0) ? 32'hC600_3B88 : {~a[15:0], a[15:0]};
    endfunction

    instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .MemRead(MemRead), .MemAddr(MemAddr),
        .MemReady(MemReady), .MemData(MemData), .Redirect(Redirect), .RedirectPc(RedirectPc),
        .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr), .InstrPc(InstrPc), .Pc(Pc)
    );

    instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_top (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .MemRead(r1), .MemAddr(a1),
        .MemReady(r1), .MemData(word(a1)), .Redirect(1'b0), .RedirectPc(32'h0),
        .InstrValid(v1), .InstrReady(1'b1), .Instr(i1), .InstrPc(ip1), .Pc(pc1)
    );

    // Memory with a programmable number of wait cycles per request
    assign MemReady = force_ready | (MemRead && wcnt == mem_wait);
    assign MemData  = word(MemAddr);
    always @(posedge Clock) wcnt <= (Reset || !MemRead || MemReady) ? 0 : wcnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !InstrValid; i++) tick();
        check("wait_valid", 32'(InstrValid), 32'h1);
    endtask

    // Model: the delivered stream is sequential words from the last reset/redirect target
    logic [31:0] exp_pc, p_addr, p_instr, p_ipc;
    logic        have_prev = 1'b0, p_read, p_ready, p_valid, p_irdy, p_redir;
    always @(negedge Clock) begin
        if (Reset) begin
            exp_pc    = 32'h0;
            have_prev = 1'b0;
        end else begin
            check("rd_vs_valid", 32'(MemRead & InstrValid), 32'h0);
            if (have_prev && p_read && !p_ready) begin
                check("mem_hold_read", 32'(MemRead), 32'h1);
                check("mem_hold_addr", MemAddr, p_addr);
            end
            if (have_prev && p_valid && !p_irdy && !p_redir) begin
                check("instr_hold_valid", 32'(InstrValid), 32'h1);
                check("instr_hold_word", Instr, p_instr);
                check("instr_hold_pc", InstrPc, p_ipc);
            end
            if (Redirect) exp_pc = {RedirectPc[31:2], 2'b00};
            else if (InstrValid && InstrReady) begin
                check("stream_pc", InstrPc, exp_pc);
                check("stream_word", Instr, word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                hs_count++;
            end
            {p_read, p_ready, p_addr, p_valid, p_irdy, p_redir} = {MemRead, MemReady, MemAddr, InstrValid, InstrReady, Redirect};
            {p_instr, p_ipc} = {Instr, InstrPc};
            have_prev = 1'b1;
        end
    end

    initial begin
        Reset = 1; Enable = 0; Redirect = 0; RedirectPc = 0; InstrReady = 1; force_ready = 0;
        repeat (3) tick();
        check("rst_memread", 32'(MemRead), 32'h0);
        check("rst_memaddr", MemAddr, 32'h0);
        check("rst_valid", 32'(InstrValid), 32'h0);
        check("rst_instr", Instr, 32'h0);
        check("rst_instrpc", InstrPc, 32'h0);
        check("rst_pc", Pc, 32'h0);
        check("rst_pc_top", pc1, 32'hFFFF_FFFC);
        // zero-wait streaming
        Reset = 0; Enable = 1;
        tick();
        check("t1_read0", 32'(MemRead), 32'h1);
        check("t1_addr0", MemAddr, 32'h0);
        check("t1_novalid", 32'(InstrValid), 32'h0);
        tick();
        check("t1_valid", 32'(InstrValid), 32'h1);
        check("t1_instr", Instr, 32'hC600_3B88);
        check("t1_instrpc", InstrPc, 32'h0);
        check("t1_pc", Pc, 32'h4);
        check("t5_valid", 32'(v1), 32'h1);
        check("t5_instrpc", ip1, 32'hFFFF_FFFC);
        check("t5_instr", i1, 32'h0003_FFFC);
        check("t5_pc_wrap", pc1, 32'h0);
        tick();
        check("t1_addr4", MemAddr, 32'h4);
        check("t1_novalid2", 32'(InstrValid), 32'h0);
        check("t5_read", 32'(r1), 32'h1);
        check("t5_addr_wrap", a1, 32'h0);
        tick();
        check("t1_instrpc4", InstrPc, 32'h4);
        tick();
        check("t1_addr8", MemAddr, 32'h8);
        // decoder stall in HOLD
        InstrReady = 0;
        tick();
        check("t2_instrpc8", InstrPc, 32'h8);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_stall_valid", 32'(InstrValid), 32'h1);
            check("t2_stall_pc", InstrPc, 32'h8);
            check("t2_stall_word", Instr, 32'hFFF7_0008);
            check("t2_stall_noread", 32'(MemRead), 32'h0);
        end
        InstrReady = 1;
        tick();
        check("t2_next_read", 32'(MemRead), 32'h1);
        check("t2_next_addr", MemAddr, 32'hC);
        // redirect during a slow fetch
        Reset = 1; mem_wait = 3;
        repeat (2) tick();
        Reset = 0;
        tick();
        check("t3_addr0", MemAddr, 32'h0);
        Redirect = 1; RedirectPc = 32'h103;
        tick();
        Redirect = 0;
        check("t3_pc", Pc, 32'h100);
        for (int i = 0; i < 3; i++) begin
            check("t3_drain_read", 32'(MemRead), 32'h1);
            check("t3_drain_addr", MemAddr, 32'h0);
            check("t3_drain_novalid", 32'(InstrValid), 32'h0);
            if (i < 2) tick();
        end
        tick();
        check("t3_refetch_read", 32'(MemRead), 32'h1);
        check("t3_refetch_addr", MemAddr, 32'h100);
        check("t3_refetch_novalid", 32'(InstrValid), 32'h0);
        wait_valid(10);
        check("t3_instrpc", InstrPc, 32'h100);
        check("t3_instr", Instr, 32'hFEFF_0100);
        // redirect while holding with decoder ready
        hs_mark = hs_count;
        Redirect = 1; RedirectPc = 32'h200; mem_wait = 0;
        tick();
        Redirect = 0;
        check("t4_novalid", 32'(InstrValid), 32'h0);
        check("t4_no_handshake", 32'(hs_count), 32'(hs_mark));
        check("t4_addr", MemAddr, 32'h200);
        check("t4_pc", Pc, 32'h200);
        tick();
        check("t4_instrpc", InstrPc, 32'h200);
        tick();
        check("t4_addr204", MemAddr, 32'h204);
        // redirect in the same cycle memory answers
        Redirect = 1; RedirectPc = 32'h300;
        tick();
        Redirect = 0;
        check("rf_read", 32'(MemRead), 32'h1);
        check("rf_addr", MemAddr, 32'h300);
        check("rf_novalid", 32'(InstrValid), 32'h0);
        tick();
        check("rf_instrpc", InstrPc, 32'h300);
        // disable mid-operation, then redirect while idle
        Enable = 0;
        tick();
        check("en_novalid", 32'(InstrValid), 32'h0);
        check("en_noread", 32'(MemRead), 32'h0);
        check("en_pc", Pc, 32'h304);
        tick();
        check("en_idle_noread", 32'(MemRead), 32'h0);
        Redirect = 1; RedirectPc = 32'h40;
        tick();
        Redirect = 0;
        check("idle_redir_noread", 32'(MemRead), 32'h0);
        check("idle_redir_pc", Pc, 32'h40);
        Enable = 1; mem_wait = 5;
        tick();
        check("idle_fetch_addr", MemAddr, 32'h40);
        check("idle_fetch_read", 32'(MemRead), 32'h1);
        // reset mid-fetch, late ready ignored
        Reset = 1;
        tick();
        check("t6_noread", 32'(MemRead), 32'h0);
        check("t6_novalid", 32'(InstrValid), 32'h0);
        check("t6_pc", Pc, 32'h0);
        check("t6_addr", MemAddr, 32'h0);
        Reset = 0; Enable = 0; force_ready = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t6_late_noread", 32'(MemRead), 32'h0);
            check("t6_late_novalid", 32'(InstrValid), 32'h0);
            check("t6_late_pc", Pc, 32'h0);
        end
        force_ready = 0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
